// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, occupancy count, programmable almost flags,
// synchronous flush and a registered read port. Define SYNC_FIFO_ERR_EN to build sticky overflow/underflow flags.
module sync_fifo_prog #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_flush,
   input  logic                          i_wr_en,
   input  logic [DATA_WIDTH-1:0]         i_wr_data,
   input  logic                          i_rd_en,
   output logic [DATA_WIDTH-1:0]         o_rd_data,
   output logic                          o_rd_valid,
   output logic                          o_full,
   output logic                          o_empty,
   output logic                          o_almost_full,
   output logic                          o_almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]    o_count,
   output logic                          o_overflow,
   output logic                          o_underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic [PTR_W-1:0]      w_wptr_nxt;
   logic [PTR_W-1:0]      w_rptr_nxt;
   logic [CNT_W-1:0]      w_count_nxt;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   // A write into a full FIFO is only legal when a read frees the slot on the same edge.
   assign w_rd_acc = i_rd_en & ~w_empty;
   assign w_wr_acc = i_wr_en & (~w_full | i_rd_en);

   assign w_wptr_nxt = (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
   assign w_rptr_nxt = (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else if (i_flush) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rptr];
            r_rptr    <= w_rptr_nxt;
         end
         if (w_wr_acc) begin
            r_wptr <= w_wptr_nxt;
         end
         r_count <= w_count_nxt;
      end
   end

   // Storage has no reset; the write enable is masked while pointers are being cleared.
   always_ff @(posedge i_clk) begin
      if (w_wr_acc && !i_flush && !i_rst) begin
         r_mem[r_wptr] <= i_wr_data;
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (i_flush) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (i_wr_en && w_full && !i_rd_en) r_overflow  <= 1'b1;
         if (i_rd_en && w_empty)            r_underflow <= 1'b1;
      end
   end

   always @(posedge i_clk) begin
      if (!i_rst && !i_flush) begin
         assert (!(w_wr_acc && w_full && !i_rd_en));
      end
   end

   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;
`else
   assign o_overflow  = 1'b0;
   assign o_underflow = 1'b0;
`endif

   assign o_rd_data      = r_rd_data;
   assign o_rd_valid     = r_rd_valid;
   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = (r_count >= CNT_W'(AF_THRESH));
   assign o_almost_empty = (r_count <= CNT_W'(AE_THRESH));
   assign o_count        = r_count;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a DEPTH=4 instance for flags, wrap and corner cases,
// and a DEPTH=5 instance for non-power-of-two ordering and flush.
module tb_sync_fifo_prog;

`ifdef SYNC_FIFO_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   int         n_tests = 0;
   int         n_fail  = 0;

   // DEPTH=4 instance
   logic       a_flush, a_wr_en, a_rd_en;
   logic [7:0] a_wr_data, a_rd_data;
   logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
   logic [2:0] a_count;

   // DEPTH=5 instance
   logic       b_flush, b_wr_en, b_rd_en;
   logic [7:0] b_wr_data, b_rd_data;
   logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
   logic [2:0] b_count;

   always #5 clk = ~clk;

   sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) u_a (
      .i_clk(clk), .i_rst(rst), .i_flush(a_flush), .i_wr_en(a_wr_en), .i_wr_data(a_wr_data),
      .i_rd_en(a_rd_en), .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid), .o_full(a_full),
      .o_empty(a_empty), .o_almost_full(a_af), .o_almost_empty(a_ae), .o_count(a_count),
      .o_overflow(a_ovf), .o_underflow(a_udf)
   );

   sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1)) u_b (
      .i_clk(clk), .i_rst(rst), .i_flush(b_flush), .i_wr_en(b_wr_en), .i_wr_data(b_wr_data),
      .i_rd_en(b_rd_en), .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .o_full(b_full),
      .o_empty(b_empty), .o_almost_full(b_af), .o_almost_empty(b_ae), .o_count(b_count),
      .o_overflow(b_ovf), .o_underflow(b_udf)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [7:0] d);
      a_wr_en = 1'b1; a_wr_data = d;
      cyc();
      a_wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_flush = 0; a_wr_en = 0; a_rd_en = 0; a_wr_data = '0;
      b_flush = 0; b_wr_en = 0; b_rd_en = 0; b_wr_data = '0;
      cyc(); cyc();
      n_tests++; if ({a_count, a_empty, a_ae, a_full, a_af} !== {3'd0, 4'b1100}) begin n_fail++;
         $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b, expected cnt=0 e=1 ae=1 f=0 af=0", a_count, a_empty, a_ae, a_full, a_af); end
      n_tests++; if ({a_rd_valid, a_rd_data, a_ovf, a_udf} !== {1'b0, 8'h00, 2'b00}) begin n_fail++;
         $display("FAIL reset_outputs: got v=%b d=%h ovf=%b udf=%b, expected v=0 d=00 ovf=0 udf=0", a_rd_valid, a_rd_data, a_ovf, a_udf); end
      rst = 1'b0;
      cyc();
      a_write(8'hAA);
      a_write(8'hBB);
      n_tests++; if (a_count !== 3'd2) begin n_fail++;
         $display("FAIL reset_precount: got %0d expected 2", a_count); end
      // asynchronous pulse between edges
      #2 rst = 1'b1;
      #1;
      n_tests++; if ({a_count, a_empty, a_ae, a_rd_valid} !== {3'd0, 3'b110}) begin n_fail++;
         $display("FAIL reset_async: got cnt=%0d e=%b ae=%b v=%b, expected cnt=0 e=1 ae=1 v=0", a_count, a_empty, a_ae, a_rd_valid); end
      cyc();
      rst = 1'b0;
      cyc();
      a_write(8'h10);
      a_rd_en = 1'b1; cyc(); a_rd_en = 1'b0;
      n_tests++; if ({a_rd_valid, a_rd_data} !== {1'b1, 8'h10}) begin n_fail++;
         $display("FAIL reset_first_write: got v=%b d=%h, expected v=1 d=10", a_rd_valid, a_rd_data); end
      cyc();
   endtask

   task automatic test_fill_drain();
      logic [7:0] exp_d [4];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
      a_write(8'h11);
      a_write(8'h22);
      n_tests++; if ({a_count, a_af, a_ae} !== {3'd2, 2'b00}) begin n_fail++;
         $display("FAIL fill_cnt2: got cnt=%0d af=%b ae=%b, expected cnt=2 af=0 ae=0", a_count, a_af, a_ae); end
      a_write(8'h33);
      n_tests++; if ({a_count, a_af, a_full} !== {3'd3, 2'b10}) begin n_fail++;
         $display("FAIL fill_cnt3: got cnt=%0d af=%b f=%b, expected cnt=3 af=1 f=0", a_count, a_af, a_full); end
      a_write(8'h44);
      n_tests++; if ({a_count, a_af, a_full} !== {3'd4, 2'b11}) begin n_fail++;
         $display("FAIL fill_cnt4: got cnt=%0d af=%b f=%b, expected cnt=4 af=1 f=1", a_count, a_af, a_full); end
      a_write(8'h55);
      n_tests++; if ({a_count, a_full} !== {3'd4, 1'b1}) begin n_fail++;
         $display("FAIL fill_drop: got cnt=%0d f=%b, expected cnt=4 f=1", a_count, a_full); end
      a_rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_tests++; if ({a_rd_valid, a_rd_data} !== {1'b1, exp_d[i]}) begin n_fail++;
            $display("FAIL drain_%0d: got v=%b d=%h, expected v=1 d=%h", i, a_rd_valid, a_rd_data, exp_d[i]); end
      end
      a_rd_en = 1'b0;
      n_tests++; if ({a_empty, a_count} !== {1'b1, 3'd0}) begin n_fail++;
         $display("FAIL drain_empty: got e=%b cnt=%0d, expected e=1 cnt=0", a_empty, a_count); end
      cyc();
      n_tests++; if (a_rd_valid !== 1'b0) begin n_fail++;
         $display("FAIL drain_idle_valid: got %b expected 0", a_rd_valid); end
   endtask

   task automatic test_full_rdwr();
      logic [7:0] exp_d [4];
      exp_d[0] = 8'h22; exp_d[1] = 8'h33; exp_d[2] = 8'h44; exp_d[3] = 8'h66;
      a_write(8'h11); a_write(8'h22); a_write(8'h33); a_write(8'h44);
      a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 8'h66;
      cyc();
      a_wr_en = 1'b0;
      n_tests++; if ({a_rd_valid, a_rd_data, a_count, a_full} !== {1'b1, 8'h11, 3'd4, 1'b1}) begin n_fail++;
         $display("FAIL full_rdwr: got v=%b d=%h cnt=%0d f=%b, expected v=1 d=11 cnt=4 f=1", a_rd_valid, a_rd_data, a_count, a_full); end
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_tests++; if ({a_rd_valid, a_rd_data} !== {1'b1, exp_d[i]}) begin n_fail++;
            $display("FAIL full_drain_%0d: got v=%b d=%h, expected v=1 d=%h", i, a_rd_valid, a_rd_data, exp_d[i]); end
      end
      a_rd_en = 1'b0;
      cyc();
   endtask

   task automatic test_empty_rdwr();
      a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 8'hA5;
      cyc();
      a_wr_en = 1'b0; a_rd_en = 1'b0;
      n_tests++; if ({a_rd_valid, a_count, a_empty} !== {1'b0, 3'd1, 1'b0}) begin n_fail++;
         $display("FAIL empty_rdwr: got v=%b cnt=%0d e=%b, expected v=0 cnt=1 e=0", a_rd_valid, a_count, a_empty); end
      a_rd_en = 1'b1; cyc(); a_rd_en = 1'b0;
      n_tests++; if ({a_rd_valid, a_rd_data, a_count} !== {1'b1, 8'hA5, 3'd0}) begin n_fail++;
         $display("FAIL empty_rdwr_read: got v=%b d=%h cnt=%0d, expected v=1 d=a5 cnt=0", a_rd_valid, a_rd_data, a_count); end
      cyc();
   endtask

   task automatic test_depth5();
      logic [7:0] exp_next;
      exp_next = 8'h01;
      for (int i = 0; i < 12; i++) begin
         b_wr_en = 1'b1; b_wr_data = 8'(i + 1); b_rd_en = (i >= 4);
         cyc();
         if (i >= 4) begin
            n_tests++; if ({b_rd_valid, b_rd_data} !== {1'b1, exp_next}) begin n_fail++;
               $display("FAIL d5_interleave_%0d: got v=%b d=%h, expected v=1 d=%h", i, b_rd_valid, b_rd_data, exp_next); end
            exp_next = exp_next + 8'h01;
         end
      end
      b_wr_en = 1'b0;
      n_tests++; if ({b_count, b_af, b_full} !== {3'd4, 2'b10}) begin n_fail++;
         $display("FAIL d5_count: got cnt=%0d af=%b f=%b, expected cnt=4 af=1 f=0", b_count, b_af, b_full); end
      b_rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_tests++; if ({b_rd_valid, b_rd_data} !== {1'b1, exp_next}) begin n_fail++;
            $display("FAIL d5_drain_%0d: got v=%b d=%h, expected v=1 d=%h", i, b_rd_valid, b_rd_data, exp_next); end
         exp_next = exp_next + 8'h01;
      end
      b_rd_en = 1'b0;
      n_tests++; if (b_empty !== 1'b1) begin n_fail++;
         $display("FAIL d5_empty: got %b expected 1", b_empty); end
      for (int i = 0; i < 3; i++) begin
         b_wr_en = 1'b1; b_wr_data = 8'h21 + 8'(i); cyc();
      end
      b_wr_en = 1'b0;
      n_tests++; if (b_count !== 3'd3) begin n_fail++;
         $display("FAIL d5_preflush: got cnt=%0d expected 3", b_count); end
      b_flush = 1'b1; b_wr_en = 1'b1; b_wr_data = 8'h77;
      cyc();
      b_flush = 1'b0; b_wr_en = 1'b0;
      n_tests++; if ({b_count, b_empty, b_rd_valid, b_rd_data} !== {3'd0, 2'b10, 8'h0C}) begin n_fail++;
         $display("FAIL d5_flush: got cnt=%0d e=%b v=%b d=%h, expected cnt=0 e=1 v=0 d=0c", b_count, b_empty, b_rd_valid, b_rd_data); end
      b_wr_en = 1'b1; b_wr_data = 8'h30; cyc(); b_wr_en = 1'b0;
      b_rd_en = 1'b1; cyc(); b_rd_en = 1'b0;
      n_tests++; if ({b_rd_valid, b_rd_data, b_count} !== {1'b1, 8'h30, 3'd0}) begin n_fail++;
         $display("FAIL d5_postflush: got v=%b d=%h cnt=%0d, expected v=1 d=30 cnt=0", b_rd_valid, b_rd_data, b_count); end
   endtask

   task automatic test_errors();
      a_flush = 1'b1; cyc(); a_flush = 1'b0;
      n_tests++; if ({a_ovf, a_udf} !== 2'b00) begin n_fail++;
         $display("FAIL err_clear: got ovf=%b udf=%b, expected 0 0", a_ovf, a_udf); end
      a_write(8'h01); a_write(8'h02); a_write(8'h03); a_write(8'h04);
      n_tests++; if (a_ovf !== 1'b0) begin n_fail++;
         $display("FAIL err_no_ovf_fill: got %b expected 0", a_ovf); end
      a_write(8'h05);
      n_tests++; if ({a_ovf, a_count} !== {ERR, 3'd4}) begin n_fail++;
         $display("FAIL err_ovf: got ovf=%b cnt=%0d, expected ovf=%b cnt=4", a_ovf, a_count, ERR); end
      a_rd_en = 1'b1; cyc(); a_rd_en = 1'b0;
      n_tests++; if ({a_ovf, a_udf, a_rd_data} !== {ERR, 1'b0, 8'h01}) begin n_fail++;
         $display("FAIL err_ovf_sticky: got ovf=%b udf=%b d=%h, expected ovf=%b udf=0 d=01", a_ovf, a_udf, a_rd_data, ERR); end
      a_flush = 1'b1; cyc(); a_flush = 1'b0;
      n_tests++; if ({a_ovf, a_count} !== {1'b0, 3'd0}) begin n_fail++;
         $display("FAIL err_ovf_flush: got ovf=%b cnt=%0d, expected ovf=0 cnt=0", a_ovf, a_count); end
      a_rd_en = 1'b1; cyc(); a_rd_en = 1'b0;
      n_tests++; if ({a_udf, a_ovf, a_rd_valid, a_count} !== {ERR, 2'b00, 3'd0}) begin n_fail++;
         $display("FAIL err_udf: got udf=%b ovf=%b v=%b cnt=%0d, expected udf=%b ovf=0 v=0 cnt=0", a_udf, a_ovf, a_rd_valid, a_count, ERR); end
      cyc();
      n_tests++; if (a_udf !== ERR) begin n_fail++;
         $display("FAIL err_udf_sticky: got %b expected %b", a_udf, ERR); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_full_rdwr();
      test_empty_rdwr();
      test_depth5();
      test_errors();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
